multiply_seq: RTL and testbench

MULTIPLY_SEQ -- requirements
Module: multiply_seq

---
 rtl/multiply_seq.sv | 127 ++++++++++++
 tb/tb_multiply_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/multiply_seq.sv
// multiply_seq: sequential radix-2 shift-add multiplier.
// Supports signed (two's-complement) and unsigned operands, with valid/ready
// handshakes on both sides. The latency is fixed at L2 cycles in CALC.
// Signed operands are converted to magnitudes, multiplied unsigned, and the
// sign is applied once, when the result is loaded into the output register.

module multiply_seq #(
    parameter int L1 = 8,   // multiplicand width (>= 2)
    parameter int L2 = 8    // multiplier width (>= 2); also the iteration count
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [L1-1:0]      in1,
    input  logic [L2-1:0]      in2,
    input  logic               sgn,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [L1+L2-1:0]   out
);

    localparam int PW = L1 + L2;          // product width
    localparam int CW = $clog2(L2 + 1);   // step counter width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [L1-1:0]    mcand_q, mcand_d;   // multiplicand magnitude
    // Upper L1 bits hold the running partial sum. Lower L2 bits hold the
    // not-yet-consumed multiplier bits, which shift out one per step.
    logic [PW-1:0]    acc_q,   acc_d;
    logic             neg_q,   neg_d;     // result sign
    logic [CW-1:0]    cnt_q,   cnt_d;     // CALC steps already taken
    logic [PW-1:0]    out_q,   out_d;

    // Operand magnitudes, kept unsigned at full width so that the most
    // negative input maps to 2^(L-1) without overflow.
    logic [L1-1:0]    mag1;
    logic [L2-1:0]    mag2;
    assign mag1 = (sgn && in1[L1-1]) ? (~in1 + L1'(1)) : in1;
    assign mag2 = (sgn && in2[L2-1]) ? (~in2 + L2'(1)) : in2;

    // One shift-add step. The sum keeps its carry bit, and that bit becomes
    // the new MSB after the right shift.
    logic [L1:0]      sum;
    logic [PW-1:0]    step;
    logic [PW-1:0]    result;
    logic             last_step;
    assign sum       = {1'b0, acc_q[PW-1:L2]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    assign step      = {sum, acc_q[L2-1:1]};
    // Negating zero gives zero, so a zero product can never become a negative zero.
    assign result    = neg_q ? (~step + PW'(1)) : step;
    assign last_step = (cnt_q == CW'(L2 - 1));

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out       = out_q;

    // Next-state and datapath control for the IDLE -> CALC -> DONE sequence.
    always_comb begin
        // NOTE: every signal assigned in this block gets a default first. A path
        // that leaves a signal unassigned would otherwise infer a latch.
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;
        out_d   = out_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    mcand_d = mag1;
                    acc_d   = {{L1{1'b0}}, mag2};
                    neg_d   = sgn & (in1[L1-1] ^ in2[L2-1]);
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                // in_valid is not looked at here, so a new request cannot
                // disturb the operation in flight.
                acc_d = step;
                cnt_d = cnt_q + CW'(1);
                if (last_step) begin
                    out_d   = result;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register. Reset is asynchronous and aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= '0;
            acc_q   <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge, whatever the statement order.
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_multiply_seq.sv
// Self-checking bench for multiply_seq. The bench instantiates two DUTs:
// a = 8x8, b = 4x12 (the parameter sweep).

module tb_multiply_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid_a, in_ready_a, sgn_a, out_valid_a, out_ready_a;
    logic [7:0]  in1_a, in2_a;
    logic [15:0] out_a;

    logic        in_valid_b, in_ready_b, sgn_b, out_valid_b, out_ready_b;
    logic [3:0]  in1_b;
    logic [11:0] in2_b;
    logic [15:0] out_b;

    int n_checks = 0;
    int n_errors = 0;
    logic [15:0] last_a;   // product that DUT a should currently be holding

    multiply_seq #(.L1(8), .L2(8)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in1(in1_a), .in2(in2_a), .sgn(sgn_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out(out_a)
    );

    multiply_seq #(.L1(4), .L2(12)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in1(in1_b), .in2(in2_b), .sgn(sgn_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out(out_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: interpret the operands as integers and multiply.
    function automatic int to_int(input logic [31:0] v, input int w, input logic s);
        if (s && v[w-1]) return int'(v) - (1 << w);
        return int'(v);
    endfunction

    function automatic logic [15:0] ref_prod(input logic [31:0] a, input int wa,
                                             input logic [31:0] b, input int wb,
                                             input logic s);
        logic [31:0] p;
        p = to_int(a, wa, s) * to_int(b, wb, s);
        return p[15:0];
    endfunction

    // Run one operation on DUT a. hold = cycles with out_ready=0 in DONE.
    // poke = drive in_valid with junk and out_ready=1 throughout CALC.
    task automatic op_a(input logic [7:0] x, input logic [7:0] y, input logic s,
                        input logic [15:0] exp, input int hold, input bit poke);
        int lat;
        bit calc_ok;
        check("a_in_ready_idle", in_ready_a, 1);
        in_valid_a = 1; in1_a = x; in2_a = y; sgn_a = s; out_ready_a = 0;
        @(posedge clk); #1;
        in_valid_a = poke; in1_a = 8'($urandom); in2_a = 8'($urandom); sgn_a = ~s;
        out_ready_a = poke;
        lat = 0;
        calc_ok = 1;
        while (!out_valid_a && lat < 40) begin
            if (out_a !== last_a || in_ready_a !== 1'b0) calc_ok = 0;
            @(posedge clk); #1;
            lat++;
            if (poke) begin in1_a = 8'($urandom); in2_a = 8'($urandom); end
        end
        in_valid_a = 0; out_ready_a = 0;
        check("a_calc_out_hold", calc_ok, 1);
        check("a_latency", lat, 8);
        check("a_product", out_a, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("a_bp_out_stable", out_a, exp);
            check("a_bp_valid", out_valid_a, 1);
            check("a_bp_in_ready", in_ready_a, 0);
        end
        out_ready_a = 1;
        @(posedge clk); #1;
        out_ready_a = 0;
        check("a_back_idle_ready", in_ready_a, 1);
        check("a_back_idle_valid", out_valid_a, 0);
        check("a_idle_out_hold", out_a, exp);
        last_a = exp;
    endtask

    // Run one operation on DUT b (L1=4, L2=12).
    task automatic op_b(input logic [3:0] x, input logic [11:0] y, input logic s);
        int lat;
        logic [15:0] exp;
        exp = ref_prod(32'(x), 4, 32'(y), 12, s);
        in_valid_b = 1; in1_b = x; in2_b = y; sgn_b = s; out_ready_b = 0;
        @(posedge clk); #1;
        in_valid_b = 0; in1_b = 4'($urandom); in2_b = 12'($urandom);
        lat = 0;
        while (!out_valid_b && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b_latency", lat, 12);
        check("b_product", out_b, exp);
        out_ready_b = 1;
        @(posedge clk); #1;
        out_ready_b = 0;
        check("b_back_idle", in_ready_b, 1);
    endtask

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[9];

    initial begin
        bit saw_valid;
        logic [7:0] rx, ry;
        logic rs;

        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};  // 255*255
        vecs[1] = '{8'h80, 8'h80, 1'b1, 16'h4000};  // -128*-128
        vecs[2] = '{8'hFF, 8'h7F, 1'b1, 16'hFF81};  // -1*127
        vecs[3] = '{8'h00, 8'hFF, 1'b1, 16'h0000};  // 0*-1, no negative zero
        vecs[4] = '{8'h80, 8'h01, 1'b1, 16'hFF80};  // -128*1
        vecs[5] = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};  // 127*127
        vecs[6] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};  // -1*-1
        vecs[7] = '{8'h80, 8'hFF, 1'b0, 16'h7F80};  // 128*255
        vecs[8] = '{8'h00, 8'h00, 1'b0, 16'h0000};  // 0*0

        in_valid_a = 0; in1_a = 0; in2_a = 0; sgn_a = 0; out_ready_a = 0;
        in_valid_b = 0; in1_b = 0; in2_b = 0; sgn_b = 0; out_ready_b = 0;
        last_a = 16'h0;
        rst_n = 0;
        #1;
        check("rst_in_ready_a", in_ready_a, 1);
        check("rst_out_valid_a", out_valid_a, 0);
        check("rst_out_a", out_a, 0);
        check("rst_in_ready_b", in_ready_b, 1);
        check("rst_out_b", out_b, 0);
        #11 rst_n = 1;   // released between edges; the first edge may accept

        for (int i = 0; i < 9; i++)
            op_a(vecs[i].x, vecs[i].y, vecs[i].s, vecs[i].exp, 0, 0);

        // Backpressure: 6*7 held for 5 cycles.
        op_a(8'd6, 8'd7, 1'b0, 16'd42, 5, 0);
        // in_valid and out_ready activity during CALC must be ignored.
        op_a(8'd200, 8'd3, 1'b0, 16'd600, 0, 1);
        op_a(8'hF6, 8'd9, 1'b1, 16'hFFA6, 1, 1);  // -10*9 = -90

        // Reset asserted at CALC cycle 4 aborts the operation.
        in_valid_a = 1; in1_a = 8'h55; in2_a = 8'h33; sgn_a = 0;
        @(posedge clk); #1;
        in_valid_a = 0;
        repeat (4) @(posedge clk);
        #2 rst_n = 0;
        #1;
        check("midcalc_rst_valid", out_valid_a, 0);
        check("midcalc_rst_out", out_a, 0);
        check("midcalc_rst_ready", in_ready_a, 1);
        #1 rst_n = 1;
        last_a = 16'h0;
        saw_valid = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid_a) saw_valid = 1;
        end
        check("rst_abort_no_result", saw_valid, 0);
        op_a(8'd3, 8'd5, 1'b0, 16'd15, 0, 0);

        // Random operands against the reference model.
        for (int i = 0; i < 25; i++) begin
            rx = 8'($urandom); ry = 8'($urandom); rs = 1'($urandom);
            op_a(rx, ry, rs, ref_prod(32'(rx), 8, 32'(ry), 8, rs), $urandom_range(0, 2), 1'($urandom));
        end

        // Parameter sweep: L1=4, L2=12, corners first, then random operands.
        op_b(4'h8, 12'h800, 1'b1);
        op_b(4'hF, 12'hFFF, 1'b0);
        op_b(4'h0, 12'h800, 1'b1);
        for (int i = 0; i < 25; i++)
            op_b(4'($urandom), 12'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
